// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcodes, ALU codes, field encodings and the ID/EX control bundle
package ctrl_pkg;
  localparam logic [6:0] OP_LOAD = 7'd3, OP_IMM = 7'd19, OP_AUIPC = 7'd23, OP_STORE = 7'd35, OP_REG = 7'd51;
  localparam logic [6:0] OP_LUI = 7'd55, OP_BRANCH = 7'd99, OP_JALR = 7'd103, OP_JAL = 7'd111;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MULDIV = 7'b0000001;
  localparam logic [4:0] ALU_ADD = 5'b00000, ALU_SUB = 5'b00001, ALU_AND = 5'b00010, ALU_XOR = 5'b00011;
  localparam logic [4:0] ALU_OR = 5'b00100, ALU_BEQ = 5'b00101, ALU_BGEU = 5'b00110, ALU_SLTU = 5'b00111;
  localparam logic [4:0] ALU_BNE = 5'b01000, ALU_MUL = 5'b01001, ALU_SLL = 5'b01010, ALU_SRL = 5'b01011;
  localparam logic [4:0] ALU_SRA = 5'b01100, ALU_BGE = 5'b01101, ALU_SLT = 5'b01110, ALU_MULHU = 5'b01111;
  localparam logic [4:0] ALU_DIVU = 5'b10000, ALU_REMU = 5'b10001;
  localparam logic [2:0] RS_ALU = 3'b000, RS_MEM = 3'b001, RS_PC4 = 3'b010, RS_IMM = 3'b011, RS_PCIMM = 3'b100;
  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011, IMM_J = 3'b100;
  localparam logic [1:0] MS_BYTE = 2'b00, MS_HALF = 2'b01, MS_WORD = 2'b10;
  typedef enum logic {RUN, DIV_WAIT} state_t;
  typedef struct packed {
    logic       valid;
    logic [2:0] result_src;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic [4:0] alu_control;
    logic       alu_src;
    logic [2:0] imm_src;
    logic       jalr_ctrl;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_bundle_t;
  function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000: return alt ? ALU_SUB : ALU_ADD;
      3'b001: return ALU_SLL;
      3'b010: return ALU_SLT;
      3'b011: return ALU_SLTU;
      3'b100: return ALU_XOR;
      3'b101: return alt ? ALU_SRA : ALU_SRL;
      3'b110: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic logic [4:0] branch_alu(input logic [2:0] f3);
    case (f3)
      3'b000: return ALU_BEQ;
      3'b001: return ALU_BNE;
      3'b100: return ALU_SLT;
      3'b101: return ALU_BGE;
      3'b110: return ALU_SLTU;
      default: return ALU_BGEU;
    endcase
  endfunction
  function automatic logic [4:0] muldiv_alu(input logic [2:0] f3);
    case (f3)
      3'b000: return ALU_MUL;
      3'b011: return ALU_MULHU;
      3'b101: return ALU_DIVU;
      default: return ALU_REMU;
    endcase
  endfunction
endpackage

// File: rtl/pipelined_control_unit_decoder.sv
// ctrl_decoder: combinational RV32I+M subset decode of one instruction word into a control bundle
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_M       = 1'b1,
  parameter bit ENABLE_SUBWORD = 1'b1
) (
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output logic         illegal,
  output logic         is_div
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic bad, div, unused_bits;
  ctrl_bundle_t c;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign unused_bits = ^{instr[24:15], instr[11:7]};
  always_comb begin
    c = '0;
    c.valid = 1'b1;
    bad = 1'b0;
    div = 1'b0;
    case (op)
      OP_LOAD: begin
        c.result_src = RS_MEM;
        c.mem_size = f3[1:0];
        c.mem_unsigned = f3[2];
        c.alu_src = 1'b1;
        c.reg_write = 1'b1;
        bad = f3[1:0] == 2'b11 || (f3[2] && f3[1]) || (!ENABLE_SUBWORD && f3 != 3'b010);
      end
      OP_STORE: begin
        c.mem_write = 1'b1;
        c.mem_size = f3[1:0];
        c.alu_src = 1'b1;
        c.imm_src = IMM_S;
        bad = f3[2] || f3[1:0] == 2'b11 || (!ENABLE_SUBWORD && f3 != 3'b010);
      end
      OP_IMM: begin
        c.alu_control = base_alu(f3, f3 == 3'b101 && f7 == F7_ALT);
        c.alu_src = 1'b1;
        c.reg_write = 1'b1;
        bad = (f3 == 3'b001 && f7 != F7_BASE) || (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT);
      end
      OP_REG: begin
        c.reg_write = 1'b1;
        if (f7 == F7_MULDIV) begin
          c.alu_control = muldiv_alu(f3);
          div = f3 == 3'b101 || f3 == 3'b111;
          bad = !ENABLE_M || !(f3 == 3'b000 || f3 == 3'b011 || div);
        end else begin
          c.alu_control = base_alu(f3, f7 == F7_ALT);
          bad = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
        end
      end
      OP_LUI: begin
        c.result_src = RS_IMM;
        c.imm_src = IMM_U;
        c.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        c.result_src = RS_PCIMM;
        c.imm_src = IMM_U;
        c.reg_write = 1'b1;
      end
      OP_BRANCH: begin
        c.branch = 1'b1;
        c.imm_src = IMM_B;
        c.alu_control = branch_alu(f3);
        bad = f3[2:1] == 2'b01;
      end
      OP_JAL: begin
        c.jump = 1'b1;
        c.result_src = RS_PC4;
        c.imm_src = IMM_J;
        c.reg_write = 1'b1;
      end
      OP_JALR: begin
        c.jump = 1'b1;
        c.jalr_ctrl = 1'b1;
        c.result_src = RS_PC4;
        c.alu_src = 1'b1;
        c.reg_write = 1'b1;
        bad = f3 != 3'b000;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      c = '0;
      c.valid = 1'b1;
      c.illegal = 1'b1;
    end
  end
  assign ctrl = c;
  assign illegal = bad;
  assign is_div = div && !bad;
endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: decode stage with registered ID/EX control bank and divide hold FSM
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W     = 5,
  parameter int DIV_LATENCY    = 32,
  parameter bit ENABLE_M       = 1'b1,
  parameter bit ENABLE_SUBWORD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid_i,
  input  logic [31:0]           instr_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  ex_valid_o,
  output logic [2:0]            result_src_o,
  output logic                  mem_write_o,
  output logic [1:0]            mem_size_o,
  output logic                  mem_unsigned_o,
  output logic [ALU_CTRL_W-1:0] alu_control_o,
  output logic                  alu_src_o,
  output logic [2:0]            imm_src_o,
  output logic                  jalr_ctrl_o,
  output logic                  reg_write_o,
  output logic                  branch_o,
  output logic                  jump_o,
  output logic                  illegal_o,
  output logic                  mdu_busy_o,
  output logic                  decode_stall_o
);
  localparam int CW = $clog2(DIV_LATENCY + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  ctrl_bundle_t bank, bank_n, dec;
  logic dec_illegal, dec_div;
  ctrl_decoder #(.ENABLE_M(ENABLE_M), .ENABLE_SUBWORD(ENABLE_SUBWORD)) u_dec (
    .instr(instr_i), .ctrl(dec), .illegal(dec_illegal), .is_div(dec_div)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bank_n = bank;
    if (flush_i) begin
      bank_n = '0;
      state_n = RUN;
      cnt_n = '0;
    end else if (state == DIV_WAIT) begin
      cnt_n = cnt - 1'b1;
      state_n = cnt == CW'(1) ? RUN : DIV_WAIT;
    end else if (stall_i) begin
      bank_n = '0;
    end else begin
      bank_n = instr_valid_i ? dec : '0;
      if (instr_valid_i && dec_div && DIV_LATENCY > 1) begin
        state_n = DIV_WAIT;
        cnt_n = CW'(DIV_LATENCY - 1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt <= '0;
      bank <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bank <= bank_n;
    end
  end
  assign ex_valid_o = bank.valid;
  assign result_src_o = bank.result_src;
  assign mem_write_o = bank.mem_write;
  assign mem_size_o = bank.mem_size;
  assign mem_unsigned_o = bank.mem_unsigned;
  assign alu_control_o = ALU_CTRL_W'(bank.alu_control);
  assign alu_src_o = bank.alu_src;
  assign imm_src_o = bank.imm_src;
  assign jalr_ctrl_o = bank.jalr_ctrl;
  assign reg_write_o = bank.reg_write;
  assign branch_o = bank.branch;
  assign jump_o = bank.jump;
  assign illegal_o = bank.illegal;
  assign mdu_busy_o = state == DIV_WAIT;
  assign decode_stall_o = stall_i || state == DIV_WAIT;
endmodule
